// File: rtl/rr_arbiter_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_8_pkg
// Description : Shared sizes, state encoding and one-hot decoder for the
//               8-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Common 3-to-8 decoder used wherever an encoded index drives one-hot selects.
    function automatic logic [N_REQ-1:0] dec_3to8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_8_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_8
// Description : Combinational round-robin picker: first set request at or
//               after ptr, wrapping 7->0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_off;

    // Rotate so that bit 0 of w_rot is requester ptr; index arithmetic wraps mod 8.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[IDX_W'(i) + ptr];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_8
// Description : 8-requester round-robin arbiter with hold-while-requested
//               ownership and a maximum-hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);

    state_t             r_state,  w_state_nxt;
    logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
    logic               r_vld,    w_vld_nxt;
    logic               r_to,     w_to_nxt;
    logic [IDX_W-1:0]   r_ptr,    w_ptr_nxt;
    logic [HOLD_W-1:0]  r_hold,   w_hold_nxt;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_to    <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_vld   <= w_vld_nxt;
            r_to    <= w_to_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_vld_nxt   = r_vld;
        w_to_nxt    = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;

        case (r_state)
            ST_IDLE: begin
                w_vld_nxt = 1'b0;
                if (en && w_any) begin
                    w_idx_nxt   = w_pick;
                    w_vld_nxt   = 1'b1;
                    w_hold_nxt  = '0;
                    w_ptr_nxt   = w_pick + IDX_W'(1);
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Leaving GRANT always lands in IDLE, which forces a dead cycle between owners.
                if (!req[r_idx]) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_hold == c_hold_last) begin
                    w_vld_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt  = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_vld_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt     = r_vld ? dec_3to8(r_idx) : '0;
    assign gnt_idx = r_idx;
    assign gnt_vld = r_vld;
    assign timeout = r_to;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_8
// Description : Directed vector bench for rr_arbiter_8 (MAX_HOLD = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    rr_arbiter_8 #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [7:0] q,
                       input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
        vec_t x;
        x.rst = r; x.en = e; x.req = q; x.gnt = g; x.idx = i; x.vld = v; x.to = t;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || timeout !== et) begin
            errors++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     name, gnt, gnt_idx, gnt_vld, timeout, eg, ei, ev, et);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, then idle with no requests
        add(1, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 1, 8'h00, 8'h00, 3'd0, 0, 0);
        // single requester 0, held then released (ptr -> 1)
        add(0, 1, 8'h01, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h01, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h01, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h00, 8'h00, 3'd0, 0, 0);
        // ptr=1 so requester 1 beats 0 (ptr -> 2)
        add(0, 1, 8'h03, 8'h02, 3'd1, 1, 0);
        add(0, 1, 8'h00, 8'h00, 3'd1, 0, 0);
        // grant 5 to move ptr to 6
        add(0, 1, 8'h20, 8'h20, 3'd5, 1, 0);
        add(0, 1, 8'h00, 8'h00, 3'd5, 0, 0);
        // ptr=6, req 6 and 0: 6 first, then wrap to 0 after a dead cycle
        add(0, 1, 8'h41, 8'h40, 3'd6, 1, 0);
        add(0, 1, 8'h41, 8'h40, 3'd6, 1, 0);
        add(0, 1, 8'h01, 8'h00, 3'd6, 0, 0);
        add(0, 1, 8'h01, 8'h01, 3'd0, 1, 0);
        add(0, 1, 8'h00, 8'h00, 3'd0, 0, 0);
        // en gating of new grants only (ptr=1)
        add(0, 0, 8'h10, 8'h00, 3'd0, 0, 0);
        add(0, 0, 8'h10, 8'h00, 3'd0, 0, 0);
        add(0, 1, 8'h10, 8'h10, 3'd4, 1, 0);
        add(0, 0, 8'h10, 8'h10, 3'd4, 1, 0);
        add(0, 0, 8'h1F, 8'h10, 3'd4, 1, 0);
        add(0, 0, 8'h00, 8'h00, 3'd4, 0, 0);
        // ptr=5, grant 2, reset mid-grant, then 0x0C picks 2 from ptr 0
        add(0, 1, 8'h04, 8'h04, 3'd2, 1, 0);
        add(1, 1, 8'h04, 8'h00, 3'd0, 0, 0);
        add(0, 1, 8'h0C, 8'h04, 3'd2, 1, 0);
        add(0, 1, 8'h00, 8'h00, 3'd2, 0, 0);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].en, vecs[n].req);
            chk($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].vld, vecs[n].to);
        end

        // all requesters held: 4-cycle grants, timeout pulse, rotation 0..7,0
        step(1, 1, 8'hFF);
        chk("rr_reset", 8'h00, 3'd0, 0, 0);
        for (int g = 0; g < 9; g++) begin
            logic [2:0] gi;
            logic [7:0] one;
            gi  = 3'(g % 8);
            one = 8'h01 << gi;
            for (int c = 0; c < 4; c++) begin
                step(0, 1, 8'hFF);
                chk($sformatf("rr_g%0d_c%0d", g, c), one, gi, 1, 0);
            end
            step(0, 1, 8'hFF);
            chk($sformatf("rr_g%0d_timeout", g), 8'h00, gi, 0, 1);
        end

        // timeout is a single pulse even when nothing re-requests
        step(0, 0, 8'h00);
        chk("to_clear", 8'h00, 3'd0, 1'b1 && 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
